// File: rtl/operand_loader_l.sv
// Byte-serial frame loader feeding the 32-bit logic unit: collects opcode, a and b,
// then holds them as one operation until the consumer acknowledges.
module operand_loader_l #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       f1f0,
  output logic             op_valid,
  input  logic             op_ack,
  output logic             err,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int NB   = WIDTH / 8;
  localparam int BC_W = $clog2(2 * NB + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  localparam logic [BC_W-1:0] LAST_OPND = BC_W'(NB - 1);
  localparam logic [BC_W-1:0] LAST_DISC = BC_W'(2 * NB - 1);

  logic [2:0]       state_q, state_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       f_q, f_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;

  // Ready depends on state alone so it never combinationally follows in_valid.
  assign in_ready = (state_q != S_ISSUE);
  assign take     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          bcnt_d = '0;
          if (in_data[7:2] == 6'd0 && in_data[1:0] != 2'b00) begin
            f_d     = in_data[1:0];
            state_d = S_LOAD_A;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_LOAD_A: begin
        if (take) begin
          for (int i = 0; i < NB; i++) begin
            if (bcnt_q == BC_W'(i)) a_d[8*i +: 8] = in_data;
          end
          if (bcnt_q == LAST_OPND) begin
            bcnt_d  = '0;
            state_d = S_LOAD_B;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (take) begin
          for (int i = 0; i < NB; i++) begin
            if (bcnt_q == BC_W'(i)) b_d[8*i +: 8] = in_data;
          end
          if (bcnt_q == LAST_OPND) begin
            bcnt_d  = '0;
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (op_ack) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        // Bad opcode: swallow the operand bytes so the stream stays frame-aligned.
        if (take) begin
          if (bcnt_q == LAST_DISC) begin
            bcnt_d  = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= 2'b01;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign f1f0     = f_q;
  assign op_valid = valid_q;
  assign err      = err_q;
  assign op_cnt   = cnt_q;

endmodule
